// File: rtl/plot_scheduler_if.sv
// Pixel and ROM bus between plot_scheduler, its background/sprite ROMs and the VGA adapter.
// master = scheduler side, slave = ROM/VGA side.
interface plot_scheduler_if;
  logic [16:0] bg_addr;
  logic [11:0] bg_data;
  logic [6:0]  spr_addr;
  logic [11:0] pac_data;
  logic [11:0] ghost_data;
  logic [8:0]  x;
  logic [8:0]  y;
  logic [11:0] colour;
  logic        plot;

  modport master (
    output bg_addr, spr_addr, x, y, colour, plot,
    input  bg_data, pac_data, ghost_data
  );
  modport slave (
    input  bg_addr, spr_addr, x, y, colour, plot,
    output bg_data, pac_data, ghost_data
  );
endinterface

// File: rtl/plot_scheduler.sv
// Sprite erase/redraw sequencer: on each frame_tick, restores background under the old
// sprite positions, then draws pac and ghost at their new positions onto the VGA plot bus.
//
// state       | meaning
// IDLE        | waiting for frame_tick
// LATCH       | capture new sprite coordinates
// ERASE_PAC   | repaint background under old pac position
// ERASE_GHOST | repaint background under old ghost position
// DRAW_PAC    | plot pac sprite at new position
// DRAW_GHOST  | plot ghost sprite at new position (last, so it sits on top)
// DONE        | commit new positions as old; done pulses on the following cycle
module plot_scheduler #(
  parameter int          SPR_W       = 10,
  parameter int          SPR_H       = 10,
  parameter int          X_OFFSET    = 51,
  parameter logic [11:0] TRANSPARENT = 12'hFFF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             frame_tick,
  input  logic [7:0]       pac_x,
  input  logic [7:0]       pac_y,
  input  logic [7:0]       ghost_x,
  input  logic [7:0]       ghost_y,
  plot_scheduler_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             overrun
);
  localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CXW-1:0] CX_LAST = CXW'(SPR_W - 1);
  localparam logic [CYW-1:0] CY_LAST = CYW'(SPR_H - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, ERASE_PAC, ERASE_GHOST, DRAW_PAC, DRAW_GHOST, DONE
  } state_t;

  state_t state, state_nxt;

  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic           drain;

  logic [7:0] new_pac_x, new_pac_y, new_ghost_x, new_ghost_y;
  logic [7:0] old_pac_x, old_pac_y, old_ghost_x, old_ghost_y;
  logic       old_valid_pac, old_valid_ghost;

  logic       in_phase, addr_cycle, phase_erase, phase_ghost;
  logic [7:0] sx, sy;
  logic [8:0] px, py;

  logic        p1_valid, p1_erase, p1_ghost;
  logic [8:0]  p1_x, p1_y;
  logic [11:0] pix_data;
  logic        pix_clip;

  logic [8:0]  x_q, y_q;
  logic [11:0] colour_q;
  logic        plot_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (frame_tick && !done) state_nxt = LATCH;
      LATCH: begin
        if (old_valid_pac)        state_nxt = ERASE_PAC;
        else if (old_valid_ghost) state_nxt = ERASE_GHOST;
        else                      state_nxt = DRAW_PAC;
      end
      ERASE_PAC:   if (drain) state_nxt = old_valid_ghost ? ERASE_GHOST : DRAW_PAC;
      ERASE_GHOST: if (drain) state_nxt = DRAW_PAC;
      DRAW_PAC:    if (drain) state_nxt = DRAW_GHOST;
      DRAW_GHOST:  if (drain) state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    in_phase    = 1'b0;
    phase_erase = 1'b0;
    phase_ghost = 1'b0;
    sx          = new_pac_x;
    sy          = new_pac_y;
    case (state)
      ERASE_PAC: begin
        in_phase = 1'b1; phase_erase = 1'b1; sx = old_pac_x; sy = old_pac_y;
      end
      ERASE_GHOST: begin
        in_phase = 1'b1; phase_erase = 1'b1; phase_ghost = 1'b1;
        sx = old_ghost_x; sy = old_ghost_y;
      end
      DRAW_PAC: in_phase = 1'b1;
      DRAW_GHOST: begin
        in_phase = 1'b1; phase_ghost = 1'b1; sx = new_ghost_x; sy = new_ghost_y;
      end
      default: ;
    endcase
    addr_cycle = in_phase && !drain;
  end

  // 9-bit sums cannot wrap for 8-bit origins plus small sprite offsets.
  assign px           = 9'(sx) + 9'(cx) + 9'(X_OFFSET);
  assign py           = 9'(sy) + 9'(cy);
  assign bus.bg_addr  = 17'(py) * 17'd320 + 17'(px);
  assign bus.spr_addr = 7'(SPR_W * int'(cy) + int'(cx));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx    <= '0;
      cy    <= '0;
      drain <= 1'b0;
    end else if (!addr_cycle) begin
      cx    <= '0;
      cy    <= '0;
      drain <= 1'b0;
    end else if (cx == CX_LAST) begin
      cx <= '0;
      if (cy == CY_LAST) begin
        cy    <= '0;
        drain <= 1'b1;
      end else begin
        cy <= cy + CYW'(1);
      end
    end else begin
      cx <= cx + CXW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      new_pac_x <= '0; new_pac_y <= '0; new_ghost_x <= '0; new_ghost_y <= '0;
      old_pac_x <= '0; old_pac_y <= '0; old_ghost_x <= '0; old_ghost_y <= '0;
      old_valid_pac   <= 1'b0;
      old_valid_ghost <= 1'b0;
    end else if (state == LATCH) begin
      new_pac_x   <= pac_x;
      new_pac_y   <= pac_y;
      new_ghost_x <= ghost_x;
      new_ghost_y <= ghost_y;
    end else if (state == DONE) begin
      old_pac_x       <= new_pac_x;
      old_pac_y       <= new_pac_y;
      old_ghost_x     <= new_ghost_x;
      old_ghost_y     <= new_ghost_y;
      old_valid_pac   <= 1'b1;
      old_valid_ghost <= 1'b1;
    end
  end

  // Pixel metadata rides one stage behind the address to meet the ROM data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p1_valid <= 1'b0;
      p1_erase <= 1'b0;
      p1_ghost <= 1'b0;
      p1_x     <= '0;
      p1_y     <= '0;
    end else begin
      p1_valid <= addr_cycle;
      p1_erase <= phase_erase;
      p1_ghost <= phase_ghost;
      p1_x     <= px;
      p1_y     <= py;
    end
  end

  always_comb begin
    pix_data = p1_erase ? bus.bg_data : (p1_ghost ? bus.ghost_data : bus.pac_data);
    pix_clip = (p1_x >= 9'd320) || (p1_y >= 9'd240);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= p1_valid && !pix_clip && (p1_erase || (pix_data != TRANSPARENT));
      if (p1_valid) begin
        x_q      <= p1_x;
        y_q      <= p1_y;
        colour_q <= pix_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (frame_tick && (busy || done)) overrun <= 1'b1;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
endmodule

// File: tb/tb_plot_scheduler.sv
// Directed bench for plot_scheduler: a frame-level slot model (phases of 100 pixels plus
// one blank slot) is compared with the DUT every cycle, with literal anchors pinning it.
module tb_plot_scheduler;
  localparam int SPR_W  = 10;
  localparam int SPR_H  = 10;
  localparam int XOFF   = 51;
  localparam int NPIX   = SPR_W * SPR_H;
  localparam int PH_LEN = NPIX + 1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] pac_x = '0, pac_y = '0, ghost_x = '0, ghost_y = '0;
  logic       busy, done, overrun;

  plot_scheduler_if bus();

  plot_scheduler #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .X_OFFSET(XOFF), .TRANSPARENT(12'hFFF)
  ) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .bus(bus), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ROM contents as pure functions of the address
  bit pac_mask = 1'b0;

  function automatic logic [11:0] bg_rom(input int a);
    return 12'(a) ^ 12'h5A5;
  endfunction

  function automatic logic [11:0] pac_rom(input int a, input bit mask);
    return (mask && a < 36) ? 12'hFFF : 12'(12'h100 + a);
  endfunction

  function automatic logic [11:0] ghost_rom(input int a);
    return 12'(12'h200 + a);
  endfunction

  always @(posedge clk) begin
    bus.bg_data    <= bg_rom(int'(bus.bg_addr));
    bus.pac_data   <= pac_rom(int'(bus.spr_addr), pac_mask);
    bus.ghost_data <= ghost_rom(int'(bus.spr_addr));
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame-level model, written only by the stimulus process
  bit m_on = 1'b0, m_oldv = 1'b0, m_ovr = 1'b0;
  int m_t0 = 0, m_n = 0, m_fid = 0, m_nph = 0;
  int m_new_px = 0, m_new_py = 0, m_new_gx = 0, m_new_gy = 0;
  int m_old_px = 0, m_old_py = 0, m_old_gx = 0, m_old_gy = 0;
  bit ph_erase[4];
  bit ph_ghost[4];
  int ph_sx[4];
  int ph_sy[4];
  bit chk_en = 1'b0;

  task automatic add_phase(input bit e, input bit g, input int sx, input int sy);
    ph_erase[m_nph] = e;
    ph_ghost[m_nph] = g;
    ph_sx[m_nph]    = sx;
    ph_sy[m_nph]    = sy;
    m_nph++;
  endtask

  task automatic tick(input int px, input int py, input int gx, input int gy);
    int rel;
    @(negedge clk);
    pac_x = 8'(px); pac_y = 8'(py); ghost_x = 8'(gx); ghost_y = 8'(gy);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    rel = (cyc - 1) - m_t0;
    if (m_on && rel >= 0 && rel <= m_n + 2) begin
      m_ovr = 1'b1;
    end else begin
      if (m_on) begin
        m_old_px = m_new_px; m_old_py = m_new_py;
        m_old_gx = m_new_gx; m_old_gy = m_new_gy;
        m_oldv = 1'b1;
      end
      m_new_px = px; m_new_py = py; m_new_gx = gx; m_new_gy = gy;
      m_nph = 0;
      if (m_oldv) begin
        add_phase(1'b1, 1'b0, m_old_px, m_old_py);
        add_phase(1'b1, 1'b1, m_old_gx, m_old_gy);
      end
      add_phase(1'b0, 1'b0, m_new_px, m_new_py);
      add_phase(1'b0, 1'b1, m_new_gx, m_new_gy);
      m_n   = m_nph * PH_LEN;
      m_t0  = cyc;
      m_on  = 1'b1;
      m_fid++;
    end
  endtask

  task automatic reset_now();
    resetn = 1'b0;
    m_on   = 1'b0;
    m_oldv = 1'b0;
    m_ovr  = 1'b0;
  endtask

  function automatic void pixel(input int ph, input int k, output int ex, output int ey,
                                output logic [11:0] col, output bit p);
    int cx, cy;
    cx = k % SPR_W;
    cy = k / SPR_W;
    ex = ph_sx[ph] + cx + XOFF;
    ey = ph_sy[ph] + cy;
    if (ph_erase[ph]) begin
      col = bg_rom(320 * ey + ex);
      p   = (ex < 320) && (ey < 240);
    end else begin
      col = ph_ghost[ph] ? ghost_rom(SPR_W * cy + cx) : pac_rom(SPR_W * cy + cx, pac_mask);
      p   = (ex < 320) && (ey < 240) && (col != 12'hFFF);
    end
  endfunction

  int n_cmp = 0, n_bad = 0;
  int f_plots = 0, f_pacdraw = 0;
  int lit_total[6] = '{0, 200, 400, 314, -1, 200};
  int lit_pac[6]   = '{0, 100, 100, 64, -1, 100};

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int rel, s, a, ph, k, ex, ey;
    bit e_plot;
    logic [11:0] e_col;
    if (chk_en) begin
      rel = cyc - m_t0;
      if (!resetn) begin
        chk("rst_plot", bus.plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_colour", bus.colour, 0);
      end else begin
        e_plot = 1'b0; e_col = '0; ex = 0; ey = 0;
        s = rel - 3;
        if (m_on && s >= 0 && s < m_n && (s % PH_LEN) < NPIX)
          pixel(s / PH_LEN, s % PH_LEN, ex, ey, e_col, e_plot);
        a = rel - 1;
        if (m_on && a >= 0 && a < m_n && (a % PH_LEN) < NPIX) begin
          ph = a / PH_LEN;
          k  = a % PH_LEN;
          if (ph_erase[ph])
            chk("bg_addr", bus.bg_addr,
                320 * (ph_sy[ph] + k / SPR_W) + ph_sx[ph] + k % SPR_W + XOFF);
          else
            chk("spr_addr", bus.spr_addr, SPR_W * (k / SPR_W) + k % SPR_W);
        end
        chk("busy", busy, (m_on && rel <= m_n + 1) ? 1 : 0);
        chk("done", done, (m_on && rel == m_n + 2) ? 1 : 0);
        chk("overrun", overrun, m_ovr);
        chk("plot", bus.plot, e_plot);
        if (e_plot) begin
          chk("x", bus.x, ex);
          chk("y", bus.y, ey);
          chk("colour", bus.colour, e_col);
        end

        if (m_on && rel == 0) begin
          f_plots   = 0;
          f_pacdraw = 0;
        end
        if (m_on && bus.plot) begin
          f_plots++;
          if (s >= 0 && s < m_n && !ph_erase[s / PH_LEN] && !ph_ghost[s / PH_LEN])
            f_pacdraw++;
        end
        if (m_on && rel == m_n + 2 && lit_total[m_fid] >= 0) begin
          chk("frame_plots", f_plots, lit_total[m_fid]);
          chk("pac_draw_plots", f_pacdraw, lit_pac[m_fid]);
        end

        if (m_fid == 1 && rel == 3) begin
          chk("f1_first_x", bus.x, 152);
          chk("f1_first_y", bus.y, 175);
          chk("f1_first_plot", bus.plot, 1);
        end
        if (m_fid == 1 && rel == 204) chk("f1_done", done, 1);
        if (m_fid == 2 && rel == 1)   chk("f2_erase_addr", bus.bg_addr, 56152);
        if (m_fid == 2 && rel == 3) begin
          chk("f2_erase_colour", bus.colour, 12'hEFD);
          chk("f2_erase_x", bus.x, 152);
        end
        if (m_fid == 2 && rel == 205) chk("f2_draw_x", bus.x, 153);
        if (m_fid == 2 && rel == 406) chk("f2_done", done, 1);
        if (m_fid == 3 && rel == 60)  chk("f3_overrun", overrun, 1);
        if (m_fid == 5 && rel == 210) chk("f5_overrun", overrun, 1);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);

    tick(101, 175, 101, 80);          // first frame, no erase
    repeat (210) @(posedge clk);
    tick(102, 175, 101, 80);          // erase both, redraw pac one pixel right
    repeat (410) @(posedge clk);

    #1 pac_mask = 1'b1;
    tick(102, 175, 255, 235);         // transparent pac pixels, ghost clipped at bottom
    repeat (49) @(posedge clk);
    tick(102, 175, 255, 235);         // lands mid-frame: ignored, overrun
    repeat (370) @(posedge clk);
    #1 pac_mask = 1'b0;

    tick(103, 175, 101, 80);
    repeat (120) @(posedge clk);
    #1 reset_now();                   // asynchronous reset mid-frame
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (5) @(posedge clk);

    tick(10, 20, 30, 40);             // after reset: no erase
    repeat (204) @(posedge clk);
    tick(10, 20, 30, 40);             // sampled in the done cycle: ignored, overrun
    repeat (10) @(posedge clk);

    #1 chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/plot_scheduler.md
PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 The block SHALL have parameter SPR_W, default 10, sprite width in pixels.
REQ-002 The block SHALL have parameter SPR_H, default 10, sprite height in pixels.
REQ-003 The block SHALL have parameter X_OFFSET, default 51, maze-to-screen x offset.
REQ-004 The block SHALL have parameter TRANSPARENT, default 12'hFFF, sprite colour key.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port frame_tick, input, 1 bit: single-cycle request to redraw sprites.
REQ-008 The block SHALL have ports pac_x, pac_y, ghost_x, ghost_y, input, 8 bits each: current sprite maze coordinates.
REQ-009 The block SHALL have port bg_addr, output, 17 bits: background ROM address.
REQ-010 The block SHALL have port bg_data, input, 12 bits: background ROM data, one-cycle read latency.
REQ-011 The block SHALL have port spr_addr, output, 7 bits: sprite ROM address, value SPR_W*cy+cx.
REQ-012 The block SHALL have ports pac_data and ghost_data, input, 12 bits each: sprite ROM data, one-cycle latency.
REQ-013 The block SHALL have ports x (9 bits), y (9 bits), colour (12 bits), plot (1 bit), all outputs and registered, driving the VGA adapter.
REQ-014 The block SHALL have ports busy, done and overrun, outputs, 1 bit each: frame in progress, one-cycle completion pulse, sticky missed tick.

Function
REQ-015 States SHALL be IDLE, LATCH, ERASE_PAC, ERASE_GHOST, DRAW_PAC, DRAW_GHOST, DONE, entered in that order; ghost is drawn last so it appears on top.
REQ-016 IDLE SHALL move to LATCH when frame_tick is sampled high; LATCH SHALL capture all four coordinate inputs into new-position registers.
REQ-017 Each ERASE/DRAW phase SHALL step counter (cx,cy) row-major over SPR_W*SPR_H cycles, then spend 1 drain cycle, for 101 cycles at default size.
REQ-018 Pixel coordinates SHALL be x = sx+cx+X_OFFSET and y = sy+cy, computed 9-bit without wrap.
REQ-019 Output x/y/colour/plot SHALL be registered one cycle after the address cycle, matching ROM latency.
REQ-020 ERASE phases SHALL use the old (previously drawn) position, drive bg_addr = 320*y + x, and plot bg_data.
REQ-021 An ERASE phase SHALL be skipped (zero cycles) while its old_valid flag is 0.
REQ-022 DRAW phases SHALL use the latched new position, plot sprite data, and hold plot low where data equals TRANSPARENT; the cycle is still consumed.
REQ-023 Any pixel with x >= 320 or y >= 240 SHALL have plot held low (clipping).
REQ-024 DONE SHALL last 1 cycle with done=1, copy new positions into the old-position registers, set both old_valid flags, and return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 The first plot SHALL occur 3 cycles after the frame_tick sample edge.
REQ-027 A full frame with both erases SHALL take 404 phase cycles; done SHALL occur 1 cycle after the last plot slot.
REQ-028 A frame_tick arriving while busy=1 SHALL be ignored and SHALL set overrun, which stays set until reset.
REQ-029 A frame_tick in the same cycle as done SHALL be ignored and SHALL set overrun.
REQ-030 plot SHALL be 0 in IDLE, LATCH, DONE and in every drain cycle.

Reset
REQ-031 Asserting resetn low, at any time including mid-frame, SHALL immediately force state IDLE.
REQ-032 On reset, plot, busy, done, overrun, x, y, colour, cx, cy and both old_valid flags SHALL all be 0.
REQ-033 After resetn deasserts, no output SHALL change until the first frame_tick.

Verification
REQ-034 After reset, tick with pac=(101,175), ghost=(101,80) -> no erase; first plot at x=152,y=175 on cycle 3; 200 plot slots; done on cycle 204.
REQ-035 Second tick with pac=(102,175) -> erase at old (152,175) with bg_addr=320*175+152=56152, then draw at x=153; done on cycle 406.
REQ-036 Sprite ROM returns 12'hFFF for 36 pixels -> exactly 64 plot pulses in that DRAW phase.
REQ-037 Ghost x=255 -> pixels with x>=320 have plot=0; no address wrap.
REQ-038 Extra frame_tick at cycle 50 of a frame -> ignored; overrun=1; frame completes normally.
REQ-039 resetn low at cycle 120 -> plot=0 and busy=0 asynchronously; the next tick performs no erase.
